// File: rtl/alarm_controller.sv
// Alarm decision logic: matches running time against the alarm setting and
// sequences ring / snooze / hold, driving the tone word and buzzer gate.
module alarm_controller #(
  parameter logic [21:0] TONE_HI        = 22'd56818,
  parameter logic [21:0] TONE_LO        = 22'd113636,
  parameter logic [23:0] BEEP_CYCLES    = 24'd12500000,
  parameter logic [7:0]  RING_TIMEOUT_S = 8'd60,
  parameter logic [5:0]  SNOOZE_MIN     = 6'd5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sec_tick,
  input  logic [4:0]  cur_hh,
  input  logic [5:0]  cur_mm,
  input  logic [5:0]  cur_ss,
  input  logic [4:0]  alarm_hh,
  input  logic [5:0]  alarm_mm,
  input  logic        alarm_en,
  input  logic        stop_alarm,
  input  logic        snooze,
  output logic [21:0] tone,
  output logic        tone_en,
  output logic        ringing,
  output logic        snoozed
);

  typedef enum logic [1:0] {IDLE, RING, SNOOZE, HOLD} state_t;

  state_t      state, state_n;
  logic        stop_q, snooze_q, match_r;
  logic [23:0] beep_cnt;
  logic [1:0]  phase;
  logic [7:0]  tout_cnt;
  logic [4:0]  target_hh;
  logic [5:0]  target_mm;

  logic        stop_ev, snooze_ev, timed_out, target_hit;
  logic        ring_entry, snooze_entry, in_ring, stay_ring;
  logic [6:0]  mm_sum;

  assign stop_ev      = stop_alarm & ~stop_q;
  assign snooze_ev    = snooze & ~snooze_q;
  assign timed_out    = (tout_cnt >= RING_TIMEOUT_S);
  assign target_hit   = sec_tick & (cur_hh == target_hh) & (cur_mm == target_mm);
  assign in_ring      = (state == RING);
  assign ring_entry   = (state_n == RING) & ~in_ring;
  assign stay_ring    = (state_n == RING) & in_ring;
  assign snooze_entry = (state_n == SNOOZE) & (state != SNOOZE);
  assign mm_sum       = 7'(cur_mm) + 7'(SNOOZE_MIN);

  // Button history and the once-per-second alarm match
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stop_q   <= 1'b0;
      snooze_q <= 1'b0;
      match_r  <= 1'b0;
    end else begin
      stop_q   <= stop_alarm;
      snooze_q <= snooze;
      match_r  <= sec_tick & alarm_en & (cur_hh == alarm_hh) &
                  (cur_mm == alarm_mm) & (cur_ss == 6'd0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Stop beats snooze when both edges land together
  always_comb begin
    state_n = state;
    case (state)
      IDLE:   if (match_r) state_n = RING;
      RING: begin
        if (!alarm_en)      state_n = IDLE;
        else if (stop_ev)   state_n = HOLD;
        else if (snooze_ev) state_n = SNOOZE;
        else if (timed_out) state_n = HOLD;
      end
      SNOOZE: begin
        if (stop_ev || !alarm_en) state_n = IDLE;
        else if (target_hit)      state_n = RING;
      end
      HOLD:   if ((cur_mm != alarm_mm) || !alarm_en) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Beep cadence, timeout, snooze target and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beep_cnt  <= 24'd0;
      phase     <= 2'd0;
      tout_cnt  <= 8'd0;
      target_hh <= 5'd0;
      target_mm <= 6'd0;
      tone      <= TONE_HI;
      tone_en   <= 1'b0;
      ringing   <= 1'b0;
      snoozed   <= 1'b0;
    end else begin
      ringing <= (state_n == RING);
      snoozed <= (state_n == SNOOZE);
      tone_en <= stay_ring & ~phase[0];
      // Tone only follows phase, which moves on segment boundaries
      if (stay_ring) tone <= phase[1] ? TONE_LO : TONE_HI;

      if (ring_entry) begin
        beep_cnt <= 24'd0;
        phase    <= 2'd0;
        tout_cnt <= 8'd0;
      end else if (in_ring) begin
        if (beep_cnt == BEEP_CYCLES - 24'd1) begin
          beep_cnt <= 24'd0;
          phase    <= phase + 2'd1;
        end else begin
          beep_cnt <= beep_cnt + 24'd1;
        end
        if (sec_tick && (tout_cnt != 8'hFF)) tout_cnt <= tout_cnt + 8'd1;
      end

      if (snooze_entry) begin
        if (mm_sum >= 7'd60) begin
          target_mm <= 6'(mm_sum - 7'd60);
          target_hh <= (cur_hh == 5'd23) ? 5'd0 : cur_hh + 5'd1;
        end else begin
          target_mm <= mm_sum[5:0];
          target_hh <= cur_hh;
        end
      end
    end
  end

endmodule
